// File: rtl/crc32blaze_s00_axi_regs.sv
// AXI4-Lite register slave for crc32blaze: CTRL/DATA/CRC/STATUS in front of a byte-serial reflected CRC-32 engine.
// Responses one cycle after handshake; engine takes one cycle per byte; writes stall on busy/BVALID, CRC reads stall on busy.
module crc32blaze_s00_axi_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            crc_busy
);

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [1:0]  REG_CTRL    = 2'd0;
  localparam logic [1:0]  REG_DATA    = 2'd1;
  localparam logic [1:0]  REG_CRC     = 2'd2;
  localparam logic [1:0]  REG_STATUS  = 2'd3;

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_RESP} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic [31:1] ctrl_scratch;
  logic [31:0] data_reg;
  logic [31:0] crc_reg;
  logic [31:0] eng_buf;
  logic [2:0]  eng_left;
  logic [15:0] wcnt;
  logic [1:0]  bresp_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;

  logic [1:0] wr_sel;
  logic [1:0] rd_sel;
  logic       wr_hs;
  logic       rd_hs;
  logic       strb_ok;
  logic [2:0] strb_bytes;
  logic       data_go;
  logic       init_go;
  logic       rd_blocked;
  logic       unused_ok;

  // One reflected CRC-32 byte step, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h000000, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign wr_sel     = S_AXI_AWADDR[3:2];
  assign rd_sel     = S_AXI_ARADDR[3:2];
  assign crc_busy   = (eng_left != 3'd0);

  assign S_AXI_AWREADY = (wr_state == W_ACCEPT);
  assign S_AXI_WREADY  = (wr_state == W_ACCEPT);
  assign S_AXI_BVALID  = (wr_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign wr_hs         = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;

  // Only contiguous low-lane strobes describe a valid byte run for the engine.
  assign strb_ok    = (S_AXI_WSTRB == 4'b0001) || (S_AXI_WSTRB == 4'b0011) ||
                      (S_AXI_WSTRB == 4'b0111) || (S_AXI_WSTRB == 4'b1111);
  assign strb_bytes = {2'b00, S_AXI_WSTRB[0]} + {2'b00, S_AXI_WSTRB[1]} +
                      {2'b00, S_AXI_WSTRB[2]} + {2'b00, S_AXI_WSTRB[3]};
  assign data_go    = wr_hs && (wr_sel == REG_DATA) && strb_ok;
  assign init_go    = wr_hs && (wr_sel == REG_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

  assign rd_blocked    = (rd_sel == REG_CRC) && crc_busy;
  assign S_AXI_ARREADY = (rd_state == R_ACCEPT) && !rd_blocked;
  assign S_AXI_RVALID  = (rd_state == R_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign rd_hs         = S_AXI_ARREADY && S_AXI_ARVALID;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    wr_state_nxt = wr_state;
    case (wr_state)
      W_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID && !crc_busy && !S_AXI_BVALID) wr_state_nxt = W_ACCEPT;
      W_ACCEPT: if (wr_hs) wr_state_nxt = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wr_state_nxt = W_IDLE;
      default:  wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      R_IDLE:   if (S_AXI_ARVALID && !S_AXI_RVALID) rd_state_nxt = R_ACCEPT;
      R_ACCEPT: if (rd_hs) rd_state_nxt = R_RESP;
      R_RESP:   if (S_AXI_RREADY) rd_state_nxt = R_IDLE;
      default:  rd_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 32'h00000000;
    case (rd_sel)
      REG_CTRL:   rd_mux = {ctrl_scratch, 1'b0};
      REG_DATA:   rd_mux = data_reg;
      REG_CRC:    rd_mux = ~crc_reg;
      REG_STATUS: rd_mux = {wcnt, 15'h0000, crc_busy};
      default:    rd_mux = 32'h00000000;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= 32'h00000000;
    end else begin
      wr_state <= wr_state_nxt;
      rd_state <= rd_state_nxt;
      if (wr_hs) begin
        bresp_q <= ((wr_sel == REG_DATA) && !strb_ok) ? RESP_SLVERR : RESP_OKAY;
      end
      if (rd_hs) begin
        rdata_q <= rd_mux;
      end
    end
  end

  // Writes are refused while busy, so a new DATA load never collides with an active byte step.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      ctrl_scratch <= '0;
      data_reg     <= 32'h00000000;
      crc_reg      <= CRC_INIT;
      eng_buf      <= 32'h00000000;
      eng_left     <= 3'd0;
      wcnt         <= 16'h0000;
    end else begin
      if (crc_busy) begin
        crc_reg  <= crc_byte(crc_reg, eng_buf[7:0]);
        eng_buf  <= {8'h00, eng_buf[31:8]};
        eng_left <= eng_left - 3'd1;
      end
      if (data_go) begin
        data_reg <= S_AXI_WDATA;
        eng_buf  <= S_AXI_WDATA;
        eng_left <= strb_bytes;
        wcnt     <= wcnt + 16'd1;
      end
      if (wr_hs && (wr_sel == REG_CTRL)) begin
        if (S_AXI_WSTRB[0]) ctrl_scratch[7:1] <= S_AXI_WDATA[7:1];
        for (int i = 1; i < 4; i++) begin
          if (S_AXI_WSTRB[i]) ctrl_scratch[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
        end
      end
      if (init_go) begin
        crc_reg <= CRC_INIT;
        wcnt    <= 16'h0000;
      end
    end
  end

endmodule

// File: doc/crc32blaze_s00_axi_regs.md
# crc32blaze_s00_axi_regs

AXI4-Lite slave (responder) for the crc32blaze peripheral: four 32-bit registers fronting a byte-serial reflected CRC-32 engine (poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF). It sits inside the crc32blaze IP at the S00_AXI port and answers single-beat AXI4-Lite transactions from the MicroBlaze or master VIP.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, address width; bits [3:2] select the register, bits [1:0] are ignored.
- S_AXI_ACLK  in  1  sole clock; everything is rising-edge.
- S_AXI_ARESETN  in  1  synchronous, active-low reset.
- S_AXI_AWADDR, S_AXI_AWPROT(3, ignored), S_AXI_AWVALID  in; S_AXI_AWREADY  out  1.
- S_AXI_WDATA(32), S_AXI_WSTRB(4), S_AXI_WVALID  in; S_AXI_WREADY  out  1.
- S_AXI_BRESP(2), S_AXI_BVALID  out; S_AXI_BREADY  in.
- S_AXI_ARADDR, S_AXI_ARPROT(3, ignored), S_AXI_ARVALID  in; S_AXI_ARREADY  out  1.
- S_AXI_RDATA(32), S_AXI_RRESP(2), S_AXI_RVALID  out; S_AXI_RREADY  in.
- crc_busy  out  1  high while the engine processes bytes.

## Operation
- Register map:
  - 0x0 CTRL: R/W scratch bits [31:1]. Writing bit0=1 loads the CRC to 0xFFFFFFFF and clears WCNT. Bit0 self-clears and always reads 0.
  - 0x4 DATA: a write feeds the engine. Reads return the last accepted DATA word.
  - 0x8 CRC: read-only, returns the bitwise inverse of the CRC register. Writes are ignored and answered OKAY.
  - 0xC STATUS: read-only. Bit0 = BUSY, bits [31:16] = WCNT, other bits 0. Writes are ignored and answered OKAY.
- DATA write with WSTRB ∈ {0001, 0011, 0111, 1111}:
  - Processes k = 1, 2, 3 or 4 bytes, lane 0 first.
  - Processing is byte-serial, one byte per cycle, LSB-first within each byte.
  - WCNT increments by 1, wrapping 0xFFFF→0x0000.
  - BRESP = OKAY.
- DATA write with any other WSTRB, including 0000: no CRC update, no WCNT change, DATA register unchanged, BRESP = SLVERR.
- CTRL write: only byte lanes with WSTRB=1 update. Bit0 acts only if lane 0 is strobed.
- RRESP is always OKAY.
- Reset: CRC reg = 0xFFFFFFFF, CTRL/DATA/WCNT = 0. All outputs are 0: AWREADY, WREADY, BVALID, ARREADY, RVALID, crc_busy, BRESP, RRESP, RDATA. Reset asserted mid-operation aborts the engine immediately; no partial update is kept.

## Timing
- Write channel states: IDLE → ACCEPT → RESP → IDLE.
  - IDLE: wait for AWVALID && WVALID && !busy && !BVALID.
  - ACCEPT: one cycle with AWREADY = WREADY = 1; address, data and strobe are latched.
  - RESP: BVALID = 1 from the cycle after the handshake, held until BREADY. BVALID drops the cycle after BVALID && BREADY.
  - AW alone or W alone is never accepted; the slave waits for both.
- All writes stall (AWREADY/WREADY held 0) while crc_busy = 1 or BVALID = 1.
- Engine timing for a DATA handshake at cycle N:
  - crc_busy = 1 during cycles N+1 .. N+k; STATUS.BUSY matches.
  - Final CRC is visible from cycle N+k+1.
  - A back-to-back DATA write can handshake no earlier than N+k+1, given BREADY was taken.
- Read channel states: IDLE → ACCEPT → RESP → IDLE.
  - ARREADY pulses one cycle when ARVALID && !RVALID.
  - RVALID and RDATA are registered and appear the cycle after the handshake, held stable until RREADY.
- Reads of 0x8 while crc_busy = 1 hold ARREADY = 0 until idle, so a CRC read never returns a mid-update value.
- Read and write channels are independent. If an AR to 0x8 and a DATA handshake occur in the same cycle, the read returns the pre-write CRC.
- CTRL INIT takes effect the cycle after its handshake. CRC reads from then on return 0x00000000.

## Test plan
- Reset, then INIT, then read 0x8 → 0x00000000, RRESP OKAY. Read 0xC → 0x00000000. All outputs are 0 during reset.
- INIT, then DATA 0x34333231 (WSTRB 1111), DATA 0x38373635 (1111), DATA 0x00000039 (0001), then read 0x8 → 0xCBF43926 ("123456789" check value). Then read 0xC → 0x00030000.
- INIT, then DATA 0x00000000 (1111). Observe crc_busy high for exactly 4 cycles after the handshake. Read 0x8 → 0x2144DF1C.
- Issue AR to 0x8 the cycle after a DATA handshake → ARREADY low until crc_busy falls; RDATA is the final value. A second DATA write issued while busy → AWREADY/WREADY stay low until idle.
- DATA write with WSTRB 0101 → BRESP SLVERR; CRC, WCNT and DATA are unchanged.
- Hold BREADY/RREADY low for 10 cycles → BVALID/RVALID and data stay stable, no new handshake occurs. Deassert S_AXI_ARESETN mid-engine → crc_busy = 0 next cycle and CRC reads 0x00000000 after release.
